// File: rtl/dfd_time_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dfd_time_sync_ctrl
// Purpose  : APB-master sequencer that resyncs one DFD time-sync slave and
//            reads back its timestamp. Optional macro: DFD_TIME_SYNC_CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dfd_time_sync_ctrl #(
   parameter int                            DFD_APB_ADDR_WIDTH = 32,
   parameter int                            DFD_APB_DATA_WIDTH = 32,
   parameter logic [DFD_APB_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
   parameter logic [DFD_APB_ADDR_WIDTH-1:0] START_OFFSET       = 'h200,
   parameter int                            XTRIG_CYCLES       = 2,
   parameter int                            POLL_MAX           = 16,
   parameter int                            TIMEOUT_CYCLES     = 64
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic                              i_sync_req,
   input  logic [63:0]                       i_sync_value,
   input  logic [7:0]                        i_marker,
   output logic                              o_busy,
   output logic                              o_done,
   output logic                              o_err,
   output logic [63:0]                       o_readback,
   output logic [DFD_APB_ADDR_WIDTH-1:0]     o_paddr,
   output logic                              o_psel,
   output logic                              o_penable,
   output logic                              o_pwrite,
   output logic [DFD_APB_DATA_WIDTH-1:0]     o_pwdata,
   output logic [DFD_APB_DATA_WIDTH/8-1:0]   o_pstrb,
   input  logic                              i_pready,
   input  logic [DFD_APB_DATA_WIDTH-1:0]     i_prdata,
   input  logic                              i_pslverr,
   output logic                              o_xtrigger
);
   localparam int AW = DFD_APB_ADDR_WIDTH;
   localparam int DW = DFD_APB_DATA_WIDTH;
   localparam int PW = $clog2(POLL_MAX + 1);
   localparam int TW = $clog2(XTRIG_CYCLES + 1);
   localparam logic [AW-1:0] TS_BASE   = BASE_ADDR + START_OFFSET;
   localparam logic [AW-1:0] OFS_THI   = AW'('h04);
   localparam logic [AW-1:0] OFS_SLO   = AW'('h08);
   localparam logic [AW-1:0] OFS_SHI   = AW'('h0C);
   localparam logic [AW-1:0] OFS_CFG   = AW'('h10);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
   localparam logic [TW-1:0] TRIG_HIGH = TW'(XTRIG_CYCLES);

   generate
      if (DFD_APB_DATA_WIDTH != 32 || XTRIG_CYCLES < 1 || POLL_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
         $error("dfd_time_sync_ctrl: unsupported parameter value");
      end
   endgenerate

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0, S_WR_SLO = 4'd1, S_WR_SHI = 4'd2, S_WR_CFG = 4'd3, S_TRIG = 4'd4,
      S_POLL   = 4'd5, S_RD_TLO = 4'd6, S_RD_THI = 4'd7, S_DONE   = 4'd8
   } state_t;

   // Every transfer state walks gap -> setup -> access, so transfers are never back-to-back.
   typedef enum logic [1:0] {PH_GAP = 2'd0, PH_SETUP = 2'd1, PH_ACCESS = 2'd2} phase_t;

   state_t        state, state_nxt;
   phase_t        phase, phase_nxt;
   logic [63:0]   value, value_nxt;
   logic [7:0]    marker, marker_nxt;
   logic [PW-1:0] poll_cnt, poll_nxt;
   logic [TW-1:0] trig_cnt, trig_nxt;
   logic          err_nxt;
   logic [63:0]   rb_nxt;
   logic          in_xfer;
   logic          write_sel;
   logic [AW-1:0] addr_sel;
   logic [DW-1:0] wdata_sel;

`ifdef DFD_TIME_SYNC_CTRL_TIMEOUT_EN
   localparam int             TMW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT_CYCLES - 1);
   logic [TMW-1:0] tmo_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset || !(in_xfer && phase == PH_ACCESS))
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 1'b1;
   end
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= S_IDLE;
         phase      <= PH_GAP;
         value      <= '0;
         marker     <= '0;
         poll_cnt   <= '0;
         trig_cnt   <= '0;
         o_err      <= 1'b0;
         o_readback <= '0;
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         value      <= value_nxt;
         marker     <= marker_nxt;
         poll_cnt   <= poll_nxt;
         trig_cnt   <= trig_nxt;
         o_err      <= err_nxt;
         o_readback <= rb_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      phase_nxt  = phase;
      value_nxt  = value;
      marker_nxt = marker;
      poll_nxt   = poll_cnt;
      trig_nxt   = trig_cnt;
      err_nxt    = o_err;
      rb_nxt     = o_readback;
      case (state)
         S_IDLE: begin
            if (i_sync_req) begin
               value_nxt  = i_sync_value;
               marker_nxt = i_marker;
               err_nxt    = 1'b0;
               poll_nxt   = '0;
               phase_nxt  = PH_GAP;
               state_nxt  = S_WR_SLO;
            end
         end
         // Trigger is high while trig_cnt < XTRIG_CYCLES; the final count is the low cycle.
         S_TRIG: begin
            if (trig_cnt == TRIG_HIGH) begin
               state_nxt = S_POLL;
               phase_nxt = PH_GAP;
            end else begin
               trig_nxt = trig_cnt + 1'b1;
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: begin
            case (phase)
               PH_GAP:   phase_nxt = PH_SETUP;
               PH_SETUP: phase_nxt = PH_ACCESS;
               default: begin
                  if (i_pready) begin
                     phase_nxt = PH_GAP;
                     if (i_pslverr) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_DONE;
                     end else begin
                        case (state)
                           S_WR_SLO: state_nxt = S_WR_SHI;
                           S_WR_SHI: state_nxt = S_WR_CFG;
                           S_WR_CFG: begin
                              trig_nxt  = '0;
                              state_nxt = S_TRIG;
                           end
                           S_POLL: begin
                              poll_nxt = poll_cnt + 1'b1;
                              if (!i_prdata[0]) begin
                                 state_nxt = S_RD_TLO;
                              end else if (poll_cnt == POLL_LAST) begin
                                 err_nxt   = 1'b1;
                                 state_nxt = S_DONE;
                              end
                           end
                           S_RD_TLO: begin
                              rb_nxt[31:0] = i_prdata[31:0];
                              state_nxt    = S_RD_THI;
                           end
                           default: begin
                              rb_nxt[63:32] = i_prdata[31:0];
                              state_nxt     = S_DONE;
                           end
                        endcase
                     end
                  end
`ifdef DFD_TIME_SYNC_CTRL_TIMEOUT_EN
                  else if (tmo_cnt == TMO_LAST) begin
                     phase_nxt = PH_GAP;
                     err_nxt   = 1'b1;
                     state_nxt = S_DONE;
                  end
`endif
               end
            endcase
         end
      endcase
   end

   always_comb begin
      addr_sel  = TS_BASE;
      write_sel = 1'b0;
      wdata_sel = '0;
      case (state)
         S_WR_SLO: begin
            addr_sel  = TS_BASE + OFS_SLO;
            write_sel = 1'b1;
            wdata_sel = DW'(value[31:0]);
         end
         S_WR_SHI: begin
            addr_sel  = TS_BASE + OFS_SHI;
            write_sel = 1'b1;
            wdata_sel = DW'(value[63:32]);
         end
         S_WR_CFG: begin
            addr_sel  = TS_BASE + OFS_CFG;
            write_sel = 1'b1;
            wdata_sel = DW'({23'b0, marker, 1'b1});
         end
         S_POLL:   addr_sel = TS_BASE + OFS_CFG;
         S_RD_THI: addr_sel = TS_BASE + OFS_THI;
         default:  addr_sel = TS_BASE;
      endcase
   end

   assign in_xfer    = (state != S_IDLE) && (state != S_TRIG) && (state != S_DONE);
   assign o_psel     = in_xfer && (phase != PH_GAP);
   assign o_penable  = in_xfer && (phase == PH_ACCESS);
   assign o_pwrite   = o_psel && write_sel;
   assign o_paddr    = o_psel ? addr_sel : '0;
   assign o_pwdata   = o_pwrite ? wdata_sel : '0;
   assign o_pstrb    = o_psel ? '1 : '0;
   assign o_xtrigger = (state == S_TRIG) && (trig_cnt < TRIG_HIGH);
   assign o_busy     = (state != S_IDLE) && (state != S_DONE);
   assign o_done     = (state == S_DONE);

endmodule
`default_nettype wire
